// File: rtl/s2p_multi.sv
// s2p_multi: multi-channel serial-to-parallel deserializer with framing,
// valid/ready output handshake and sticky overrun detection.
// Optional: define S2P_FRAME_CHECK_EN to flag mid-word Frame strobes on FrameErr.
module s2p_multi #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                         Dclk,
  input  logic                         Reset,
  input  logic                         Frame,
  input  logic [CHANNELS-1:0]          Din,
  output logic [CHANNELS*WIDTH-1:0]    Dout,
  output logic                         Valid,
  input  logic                         Ready,
  output logic                         Overrun,
  output logic                         FrameErr,
  output logic                         Busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef logic [CHANNELS-1:0][WIDTH-1:0] lanes_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lanes_t           sr_q, sr_d;
  lanes_t           dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  // Append one serial bit so that the first bit of a word ends at its final position.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST != 0) return {cur[WIDTH-2:0], b};
    else                return {b, cur[WIDTH-1:1]};
  endfunction

  // Next-state, capture and handshake logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (valid_q && Ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (Frame) begin
          for (int unsigned c = 0; c < CHANNELS; c++) sr_d[c] = shift_in('0, Din[c]);
          cnt_d   = ONE_CNT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (Frame) begin
          // Partial word dropped; this edge is bit 0 of a new word.
          for (int unsigned c = 0; c < CHANNELS; c++) sr_d[c] = shift_in('0, Din[c]);
          cnt_d = ONE_CNT;
        end else begin
          for (int unsigned c = 0; c < CHANNELS; c++) sr_d[c] = shift_in(sr_q[c], Din[c]);
          cnt_d = cnt_q + ONE_CNT;
          if (cnt_q == LAST_CNT) begin
            dout_d  = sr_d;
            valid_d = 1'b1;
            if (valid_q && !Ready) ovr_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by Reset.
  always_ff @(negedge Dclk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef S2P_FRAME_CHECK_EN
  logic ferr_q, ferr_d;

  // Sticky flag for a Frame strobe arriving while a word is in progress.
  always_comb begin
    ferr_d = ferr_q;
    if (state_q == SHIFT && Frame) ferr_d = 1'b1;
  end

  // Frame error register.
  always_ff @(negedge Dclk or posedge Reset) begin
    if (Reset) ferr_q <= 1'b0;
    else       ferr_q <= ferr_d;
  end

  assign FrameErr = ferr_q;
`else
  assign FrameErr = 1'b0;
`endif

  assign Dout    = dout_q;
  assign Valid   = valid_q;
  assign Overrun = ovr_q;
  assign Busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_s2p_multi.sv
// Bench for s2p_multi: three instances (16x2 MSB-first, 16x2 LSB-first,
// 24x4 MSB-first) checked every falling edge against a bit-list reference
// model, plus directed checks of the documented scenarios.
module tb_s2p_multi;

`ifdef S2P_FRAME_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic        Dclk = 1'b1;
  logic        Reset;
  logic [2:0]  frame;
  logic [2:0]  ready;
  logic [7:0]  din [3];
  logic [31:0] dout0, dout1;
  logic [95:0] dout2;
  logic [2:0]  valid_v, ovr_v, ferr_v, busy_v;

  int n_tests = 0;
  int n_fail  = 0;
  int rise0 = 0, rise2 = 0;

  always #5 Dclk = ~Dclk;

  s2p_multi #(.WIDTH(16), .CHANNELS(2), .MSB_FIRST(1)) u0 (
    .Dclk(Dclk), .Reset(Reset), .Frame(frame[0]), .Din(din[0][1:0]), .Dout(dout0),
    .Valid(valid_v[0]), .Ready(ready[0]), .Overrun(ovr_v[0]), .FrameErr(ferr_v[0]), .Busy(busy_v[0]));

  s2p_multi #(.WIDTH(16), .CHANNELS(2), .MSB_FIRST(0)) u1 (
    .Dclk(Dclk), .Reset(Reset), .Frame(frame[1]), .Din(din[1][1:0]), .Dout(dout1),
    .Valid(valid_v[1]), .Ready(ready[1]), .Overrun(ovr_v[1]), .FrameErr(ferr_v[1]), .Busy(busy_v[1]));

  s2p_multi #(.WIDTH(24), .CHANNELS(4), .MSB_FIRST(1)) u2 (
    .Dclk(Dclk), .Reset(Reset), .Frame(frame[2]), .Din(din[2][3:0]), .Dout(dout2),
    .Valid(valid_v[2]), .Ready(ready[2]), .Overrun(ovr_v[2]), .FrameErr(ferr_v[2]), .Busy(busy_v[2]));

  always @(posedge valid_v[0]) rise0++;
  always @(posedge valid_v[2]) rise2++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int p_w(input int i);
    return (i == 2) ? 24 : 16;
  endfunction
  function automatic int p_ch(input int i);
    return (i == 2) ? 4 : 2;
  endfunction
  function automatic bit p_msb(input int i);
    return (i != 1);
  endfunction
  function automatic logic [255:0] obs_dout(input int i);
    if (i == 0) return 256'(dout0);
    if (i == 1) return 256'(dout1);
    return 256'(dout2);
  endfunction

  // Reference model: per channel list of received bits, word assembled once full.
  bit           m_bits [3][8][32];
  int           m_cnt  [3];
  bit           m_busy [3];
  bit           m_valid[3];
  bit           m_ovr  [3];
  bit           m_ferr [3];
  logic [255:0] m_dout [3];

  task automatic model_step(input int i);
    int w, ch;
    bit msb, old_valid;
    logic [255:0] word;
    w = p_w(i); ch = p_ch(i); msb = p_msb(i);
    if (Reset) begin
      m_busy[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_ferr[i] = 0; m_dout[i] = '0;
      return;
    end
    old_valid = m_valid[i];
    if (m_valid[i] && ready[i]) m_valid[i] = 0;
    if (frame[i]) begin
      if (m_busy[i] && FCHK) m_ferr[i] = 1;
      for (int c = 0; c < ch; c++) m_bits[i][c][0] = din[i][c];
      m_cnt[i]  = 1;
      m_busy[i] = 1;
    end else if (m_busy[i]) begin
      for (int c = 0; c < ch; c++) m_bits[i][c][m_cnt[i]] = din[i][c];
      m_cnt[i]++;
      if (m_cnt[i] == w) begin
        word = '0;
        for (int c = 0; c < ch; c++)
          for (int k = 0; k < w; k++)
            word[c*w + (msb ? (w-1-k) : k)] = m_bits[i][c][k];
        m_dout[i] = word;
        if (old_valid && !ready[i]) m_ovr[i] = 1;
        m_valid[i] = 1;
        m_busy[i]  = 0;
        m_cnt[i]   = 0;
      end
    end
  endtask

  // Advance the model on every sampling edge and compare all outputs shortly after.
  always @(negedge Dclk) begin
    for (int i = 0; i < 3; i++) model_step(i);
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_dout", i),  obs_dout(i),          m_dout[i]);
      check($sformatf("u%0d_valid", i), 256'(valid_v[i]),     256'(m_valid[i]));
      check($sformatf("u%0d_ovr", i),   256'(ovr_v[i]),       256'(m_ovr[i]));
      check($sformatf("u%0d_ferr", i),  256'(ferr_v[i]),      256'(m_ferr[i]));
      check($sformatf("u%0d_busy", i),  256'(busy_v[i]),      256'(m_busy[i]));
    end
  end

  task automatic drive(input int i, input bit fr, input logic [7:0] bits, input bit rdy);
    @(posedge Dclk);
    frame[i] = fr;
    din[i]   = bits;
    ready[i] = rdy;
  endtask

  // Serialize packed lanes (lane c at [c*w +: w]); only the first nbits are sent.
  task automatic send_word(input int i, input logic [255:0] words, input bit rdy_last, input int nbits);
    int w, ch;
    bit msb;
    logic [7:0] bits;
    w = p_w(i); ch = p_ch(i); msb = p_msb(i);
    for (int k = 0; k < nbits; k++) begin
      bits = '0;
      for (int c = 0; c < ch; c++) bits[c] = words[c*w + (msb ? (w-1-k) : k)];
      drive(i, (k == 0), bits, (k == w-1) ? rdy_last : 1'b0);
    end
  endtask

  task automatic wait_done();
    @(negedge Dclk);
    #3;
  endtask

  task automatic do_reset();
    @(posedge Dclk);
    Reset = 1'b1;
    @(posedge Dclk);
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wd;
    logic [15:0]  r16;
    int r0, r2;

    Reset = 1'b1;
    frame = '0;
    ready = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;

    // Reset state
    wait_done();
    for (int i = 0; i < 3; i++) begin
      check("rst_dout",  obs_dout(i),      256'(0));
      check("rst_valid", 256'(valid_v[i]), 256'(0));
      check("rst_busy",  256'(busy_v[i]),  256'(0));
    end
    @(posedge Dclk);
    Reset = 1'b0;

    // Single word, MSB first
    send_word(0, 256'h1234_A5C3, 1'b0, 16);
    wait_done();
    check("t1_dout",  256'(dout0),      256'(32'h1234_A5C3));
    check("t1_valid", 256'(valid_v[0]), 256'(1));
    check("t1_ovr",   256'(ovr_v[0]),   256'(0));
    check("t1_ferr",  256'(ferr_v[0]),  256'(0));
    drive(0, 1'b0, 8'h0, 1'b1);
    drive(0, 1'b0, 8'h0, 1'b0);
    check("t1_accept", 256'(valid_v[0]), 256'(0));

    // Bit order, LSB first
    r16 = 16'($urandom);
    send_word(1, 256'({r16, 16'h0001}), 1'b0, 16);
    wait_done();
    check("t2_lane0", 256'(dout1[15:0]),  256'(16'h0001));
    check("t2_lane1", 256'(dout1[31:16]), 256'(r16));
    drive(1, 1'b0, 8'h0, 1'b1);
    drive(1, 1'b0, 8'h0, 1'b0);

    // Back-to-back with Ready low: overrun
    send_word(0, 256'h1111_1111, 1'b0, 16);
    send_word(0, 256'h2222_2222, 1'b0, 16);
    wait_done();
    check("t3_dout",  256'(dout0[15:0]), 256'(16'h2222));
    check("t3_valid", 256'(valid_v[0]),  256'(1));
    check("t3_ovr",   256'(ovr_v[0]),    256'(1));

    // Back-to-back with Ready on the completion edge: no overrun
    do_reset();
    send_word(0, 256'h1111_1111, 1'b0, 16);
    send_word(0, 256'h2222_2222, 1'b1, 16);
    wait_done();
    ready[0] = 1'b0;
    check("t3b_dout",  256'(dout0[15:0]), 256'(16'h2222));
    check("t3b_valid", 256'(valid_v[0]),  256'(1));
    check("t3b_ovr",   256'(ovr_v[0]),    256'(0));

    // Early Frame at bit 7 then a full word
    drive(0, 1'b0, 8'h0, 1'b1);
    wd = 256'($urandom);
    send_word(0, wd, 1'b0, 7);
    r16 = 16'($urandom);
    send_word(0, 256'({r16, 16'hBEEF}), 1'b0, 16);
    wait_done();
    check("t4_dout",  256'(dout0), 256'({r16, 16'hBEEF}));
    check("t4_valid", 256'(valid_v[0]), 256'(1));
    check("t4_ferr",  256'(ferr_v[0]),  256'(FCHK));
    check("t4_ovr",   256'(ovr_v[0]),   256'(0));

    // Reset in the middle of a word
    wd = 256'($urandom);
    send_word(0, wd, 1'b0, 9);
    @(posedge Dclk);
    #1;
    Reset = 1'b1;
    frame[0] = 1'b0;
    #1;
    check("t5_dout",  256'(dout0),      256'(0));
    check("t5_valid", 256'(valid_v[0]), 256'(0));
    check("t5_ovr",   256'(ovr_v[0]),   256'(0));
    check("t5_ferr",  256'(ferr_v[0]),  256'(0));
    check("t5_busy",  256'(busy_v[0]),  256'(0));
    r0 = rise0;
    @(posedge Dclk);
    Reset = 1'b0;
    repeat (40) drive(0, 1'b0, 8'($urandom), 1'b0);
    wait_done();
    check("t5_no_valid", 256'(rise0 - r0), 256'(0));

    // Random framing, data and ready on the 16-bit instances
    for (int n = 0; n < 400; n++) begin
      @(posedge Dclk);
      for (int i = 0; i < 2; i++) begin
        frame[i] = ($urandom_range(0, 15) == 0);
        din[i]   = 8'($urandom);
        ready[i] = ($urandom_range(0, 2) == 0);
      end
    end
    @(posedge Dclk);
    frame[1:0] = '0;
    ready[1:0] = '0;

    // Parameter sweep: 24-bit words on 4 lanes, one Valid rise per word
    do_reset();
    r2 = rise2;
    for (int n = 0; n < 20; n++) begin
      wd = '0;
      wd[31:0]  = $urandom;
      wd[63:32] = $urandom;
      wd[95:64] = $urandom;
      send_word(2, wd, 1'b0, 24);
      wait_done();
      for (int c = 0; c < 4; c++)
        check($sformatf("t6_lane%0d", c), 256'(dout2[c*24 +: 24]), 256'(wd[c*24 +: 24]));
      check("t6_valid", 256'(valid_v[2]), 256'(1));
      drive(2, 1'b0, 8'h0, 1'b1);
      repeat ($urandom_range(0, 2)) drive(2, 1'b0, 8'($urandom), 1'b0);
    end
    drive(2, 1'b0, 8'h0, 1'b0);
    wait_done();
    check("t6_rises", 256'(rise2 - r2), 256'(20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s2p_multi.md
# s2p_multi

Parametrised multi-channel serial-to-parallel deserializer for the mini stereo audio processor. It replaces the fixed 16-bit stereo input stage with configurable word width, channel count and bit order. It frames words on the `Frame` strobe, reports malformed frames, and delivers completed parallel words to the downstream filter stage through a valid/ready handshake with overrun detection.

## Interface
- `WIDTH`, 16, bits per sample word; legal range 2..32.
- `CHANNELS`, 2, number of serial lanes deserialized in lockstep; legal range 1..8. Channel 0 = left, 1 = right.
- `MSB_FIRST`, 1, bit order. 1: the first bit lands in bit WIDTH-1. 0: the first bit lands in bit 0.

- `Dclk`  in  1  serial bit clock; all state changes on the falling edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Frame`  in  1  word-start strobe; high during the first bit of a word.
- `Din`  in  CHANNELS  serial data, one bit per channel.
- `Dout`  out  CHANNELS*WIDTH  parallel words; channel c occupies bits [c*WIDTH +: WIDTH].
- `Valid`  out  1  `Dout` holds an unconsumed word.
- `Ready`  in  1  consumer accepts the word.
- `Overrun`  out  1  sticky: a word completed while the previous word was unconsumed.
- `FrameErr`  out  1  sticky: `Frame` arrived mid-word.
- `Busy`  out  1  a word is being shifted in.

## Operation
- The FSM has two states: IDLE and SHIFT. The bit counter is $clog2(WIDTH) bits wide and holds the number of bits captured.
- **IDLE:**
  - `Frame`=0: `Din` is ignored.
  - `Frame`=1: capture bit 0 of the word for every channel, set count=1, go to SHIFT.
- **SHIFT, `Frame`=0:** capture the next bit and increment count.
  - On the edge that captures bit WIDTH-1 (the last bit), copy the complete shift registers to `Dout`, set `Valid`=1, and return to IDLE.
- **SHIFT, `Frame`=1:** the partial word is discarded and nothing is written to `Dout`.
  - Restart capture with `Din` as bit 0 and set count=1.
  - Set `FrameErr` (see Configuration).
- **Back-to-back words:** `Frame` on the edge immediately after the last bit is legal. It is handled from IDLE and raises no error, so continuous framing with period WIDTH is supported.
- **Handshake:**
  - `Valid` clears on a falling edge where `Valid`=1 and `Ready`=1.
  - `Dout` is stable while `Valid`=1, unless an overrun occurs.
- **Completion while `Valid`=1 and `Ready`=0:** the new word overwrites `Dout`, `Valid` stays 1, and `Overrun` is set.
- **Completion on the same edge as an acceptance (`Ready`=1):** the new word loads, `Valid` stays 1, and `Overrun` is not set.
- **Bit placement:**
  - MSB_FIRST=1: bit k of the serial stream goes to word bit WIDTH-1-k.
  - MSB_FIRST=0: bit k of the serial stream goes to word bit k.
- `Overrun` and `FrameErr` clear only on `Reset`.
- `Busy` = (state == SHIFT).

## Timing
- **Reset:** `Reset`=1 asynchronously forces the following, and any partial word is lost. Release is sampled at the next falling edge.
  - state to IDLE and count to 0;
  - `Dout`, `Valid`, `Overrun`, `FrameErr` and `Busy` to 0;
  - the shift registers to 0.
- **Inputs:** `Frame`, `Din` and `Ready` are sampled on the falling edge of `Dclk`.
- **Latency:** `Dout` and `Valid` update on the falling edge that samples the last bit. That is WIDTH-1 edges after the edge that sampled `Frame`=1.
- **Word period:** the minimum is WIDTH edges. The maximum is unbounded, since IDLE waits indefinitely.
- **Frame width:** `Frame` high for N consecutive edges restarts on each of them. A FrameErr is flagged on every edge after the first. The word begins at the last high edge.

## Configuration
- **`S2P_FRAME_CHECK_EN` defined:** a mid-word `Frame` sets `FrameErr` (sticky) and restarts capture as described.
- **Undefined:**
  - A mid-word `Frame` still restarts capture silently.
  - `FrameErr` is tied to 0 and its register is omitted.

## Test plan
- **Single word:** WIDTH=16, CHANNELS=2, MSB_FIRST=1. Pulse `Frame` with left stream 0xA5C3 and right stream 0x1234, `Ready`=0.
  - On the 16th edge: `Dout`=0x1234_A5C3 and `Valid`=1.
  - `Overrun`=0 and `FrameErr`=0.
- **Bit order:** MSB_FIRST=0, serial bits 1,0,0,0,... on channel 0 -> `Dout[15:0]`=0x0001.
- **Back-to-back with Ready=0:** stream 0x1111 then 0x2222 with continuous framing.
  - After word 2: `Dout[15:0]`=0x2222, `Valid`=1, `Overrun`=1.
  - Repeat with `Ready`=1 asserted on the completion edge of word 2: `Overrun`=0.
- **Early Frame:** `Frame` at bit 7, then a full 0xBEEF word.
  - `Dout`=0xBEEF after 16 edges from the second `Frame`.
  - `FrameErr`=1 with the macro defined, 0 without it.
- **Reset mid-word:** assert `Reset` at bit 9 -> all outputs 0 immediately, and no `Valid` appears after release without a new `Frame`.
- **Parameter sweep:** WIDTH=24, CHANNELS=4 with random words; each lane matches its expected word and `Valid` rises exactly once per word.
